// File: rtl/pwm_ctrl_pkg.sv
// Shared types for the PWM fade controller.
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2,
    DONE      = 2'd3
  } fade_state_t;

endpackage

// File: rtl/pwm_period_tracker.sv
// Free-running phase counter that shadows the downstream PWM counter,
// flagging the last cycle of each PWM period.
module pwm_period_tracker #(
  parameter int BIT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] max_value,
  output logic                 period_end
);

  logic [BIT_WIDTH-1:0] r_phase;

  assign period_end = (r_phase == max_value);

  // Phase wraps at max_value (or naturally at 2^BIT_WIDTH); never cleared by commands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= '0;
    end else if (period_end) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + BIT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pwm_fade_controller.sv
// Fade sequencer: accepts a fade command and walks duty toward the target,
// updating only at PWM period boundaries so no period is truncated.
import pwm_ctrl_pkg::*;

module pwm_fade_controller #(
  parameter int BIT_WIDTH = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] cfg_max_value,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [BIT_WIDTH-1:0] cmd_target,
  input  logic [BIT_WIDTH-1:0] cmd_step,
  input  logic [DIV_WIDTH-1:0] cmd_div,
  input  logic                 abort,
  output logic [BIT_WIDTH-1:0] duty_out,
  output logic [BIT_WIDTH-1:0] max_value_out,
  output logic                 busy,
  output logic                 done
);

  fade_state_t          r_state, w_next;
  logic [BIT_WIDTH-1:0] r_duty, r_max, r_target, r_step;
  logic [DIV_WIDTH-1:0] r_div, r_div_cnt;
  logic                 r_done;

  logic                 w_period_end, w_accept, w_busy, w_step_ev, w_update;
  logic [BIT_WIDTH-1:0] w_tgt_clamp, w_new_duty;
  logic [BIT_WIDTH:0]   w_sum, w_diff;

  pwm_period_tracker #(.BIT_WIDTH(BIT_WIDTH)) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .max_value  (r_max),
    .period_end (w_period_end)
  );

  assign w_accept    = cmd_valid && (r_state == IDLE);
  assign w_tgt_clamp = (cmd_target > cfg_max_value) ? cfg_max_value : cmd_target;
  assign w_busy      = (r_state == RAMP_UP) || (r_state == RAMP_DOWN);
  assign w_step_ev   = w_busy && w_period_end && (r_div_cnt == r_div - DIV_WIDTH'(1));
  // Abort takes priority over a coincident step event.
  assign w_update    = w_step_ev && !abort;

  // One extra bit keeps the up-sum and down-distance free of wraparound.
  assign w_sum  = {1'b0, r_duty} + {1'b0, r_step};
  assign w_diff = {1'b0, r_duty} - {1'b0, r_target};

  // Next duty on a step event; a zero step jumps straight to the target.
  always_comb begin
    w_new_duty = r_target;
    if (r_step != '0) begin
      if (r_state == RAMP_UP) begin
        w_new_duty = (w_sum > {1'b0, r_target}) ? r_target : w_sum[BIT_WIDTH-1:0];
      end else if (r_state == RAMP_DOWN) begin
        w_new_duty = (w_diff <= {1'b0, r_step}) ? r_target : r_duty - r_step;
      end
    end
  end

  // Next-state logic for the fade FSM.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_tgt_clamp > r_duty)      w_next = RAMP_UP;
          else if (w_tgt_clamp < r_duty) w_next = RAMP_DOWN;
          else                           w_next = DONE;
        end
      end
      RAMP_UP, RAMP_DOWN: begin
        if (abort)                                     w_next = IDLE;
        else if (w_step_ev && w_new_duty == r_target)  w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Command capture, period divider, duty register and the registered done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty    <= '0;
      r_max     <= '1;
      r_target  <= '0;
      r_step    <= '0;
      r_div     <= DIV_WIDTH'(1);
      r_div_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      if (w_accept) begin
        r_max     <= cfg_max_value;
        r_target  <= w_tgt_clamp;
        r_step    <= cmd_step;
        r_div     <= (cmd_div == '0) ? DIV_WIDTH'(1) : cmd_div;
        r_div_cnt <= '0;
      end else if (w_step_ev) begin
        r_div_cnt <= '0;
      end else if (w_period_end) begin
        r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
      end
      if (w_update) r_duty <= w_new_duty;
    end
  end

  assign cmd_ready     = (r_state == IDLE);
  assign busy          = w_busy;
  assign done          = r_done;
  assign duty_out      = r_duty;
  assign max_value_out = r_max;

endmodule

// File: tb/tb_pwm_fade_controller.sv
// Directed bench for pwm_fade_controller: expected duty steps and their
// spacing are queued when a command is sent and popped as duty_out changes.
module tb_pwm_fade_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cfg_max_value;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_target;
  logic [7:0]  cmd_step;
  logic [15:0] cmd_div;
  logic        abort;
  logic [7:0]  duty_out;
  logic [7:0]  max_value_out;
  logic        busy;
  logic        done;

  typedef struct {
    logic [7:0] duty;
    int         gap;   // cycles since previous duty change; 0 = unchecked
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   exp_done = 0;

  pwm_fade_controller #(.BIT_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_max_value (cfg_max_value),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_target    (cmd_target),
    .cmd_step      (cmd_step),
    .cmd_div       (cmd_div),
    .abort         (abort),
    .duty_out      (duty_out),
    .max_value_out (max_value_out),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) done_cnt <= 0;
    else if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one command starting at a negedge; returns at the negedge after the accept edge.
  task automatic send_cmd(input logic [7:0] mx, input logic [7:0] tgt,
                          input logic [7:0] stp, input logic [15:0] dv);
    cfg_max_value = mx;
    cmd_target    = tgt;
    cmd_step      = stp;
    cmd_div       = dv;
    cmd_valid     = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_change(output int gap);
    logic [7:0] prev;
    prev = duty_out;
    gap  = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (duty_out === prev && gap < 3000);
  endtask

  task automatic expect_change(input string tag);
    exp_t e;
    int   g;
    wait_change(g);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_duty"}, 32'(duty_out), 32'(e.duty));
      if (e.gap != 0) chk({tag, "_gap"}, 32'(g), 32'(e.gap));
    end
  endtask

  // Called at the sample where duty has just reached the target.
  task automatic finish_ramp(input string tag);
    chk({tag, "_done_lag"}, 32'(done), 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd1);
    @(negedge clk);
    chk({tag, "_done_end"}, 32'(done), 32'd0);
    chk({tag, "_idle_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    exp_done++;
    chk({tag, "_done_count"}, 32'(done_cnt), 32'(exp_done));
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cfg_max_value = 8'hFF; cmd_target = '0; cmd_step = '0; cmd_div = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_duty", 32'(duty_out), 32'd0);
    chk("rst_max", 32'(max_value_out), 32'hFF);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Ramp up with a partial final step.
    send_cmd(8'd255, 8'd25, 8'd10, 16'd1);
    chk("up_busy", 32'(busy), 32'd1);
    chk("up_ready", 32'(cmd_ready), 32'd0);
    sb.push_back('{8'd10, 0});
    sb.push_back('{8'd20, 256});
    sb.push_back('{8'd25, 256});
    repeat (3) expect_change("up");
    finish_ramp("up");

    // Zero step jumps straight to 200.
    send_cmd(8'd255, 8'd200, 8'd0, 16'd1);
    sb.push_back('{8'd200, 0});
    expect_change("jump");
    finish_ramp("jump");

    // Ramp down, two periods per step.
    send_cmd(8'd255, 8'd50, 8'd60, 16'd2);
    chk("down_busy", 32'(busy), 32'd1);
    sb.push_back('{8'd140, 0});
    sb.push_back('{8'd80, 512});
    sb.push_back('{8'd50, 512});
    repeat (3) expect_change("down");
    finish_ramp("down");

    // Target above max is clamped; div 0 behaves as 1.
    send_cmd(8'd99, 8'd150, 8'd0, 16'd0);
    chk("clamp_max", 32'(max_value_out), 32'd99);
    sb.push_back('{8'd99, 0});
    expect_change("clamp");
    finish_ramp("clamp");

    // 100-cycle period confirms phase wraps at 99.
    send_cmd(8'd99, 8'd0, 8'd30, 16'd0);
    sb.push_back('{8'd69, 0});
    sb.push_back('{8'd39, 100});
    sb.push_back('{8'd9, 100});
    sb.push_back('{8'd0, 100});
    repeat (4) expect_change("wrap");
    finish_ramp("wrap");

    // Abort mid-ramp; a command offered while busy must be dropped.
    send_cmd(8'd255, 8'd200, 8'd10, 16'd1);
    sb.push_back('{8'd10, 0});
    expect_change("abort_first");
    cmd_target = 8'd5; cmd_step = 8'd0; cmd_div = 16'd1; cmd_valid = 1'b1;
    chk("busy_not_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    sb.push_back('{8'd20, 0});
    expect_change("ignored_cmd");
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_duty", 32'(duty_out), 32'd20);
    repeat (300) @(negedge clk);
    chk("abort_frozen", 32'(duty_out), 32'd20);
    chk("abort_no_done", 32'(done_cnt), 32'(exp_done));

    // Equal target: done two cycles after accept, never busy.
    send_cmd(8'd255, 8'd20, 8'd5, 16'd1);
    chk("eq_busy0", 32'(busy), 32'd0);
    chk("eq_done0", 32'(done), 32'd0);
    @(negedge clk);
    chk("eq_busy1", 32'(busy), 32'd0);
    chk("eq_done1", 32'(done), 32'd1);
    @(negedge clk);
    chk("eq_done2", 32'(done), 32'd0);
    chk("eq_ready", 32'(cmd_ready), 32'd1);
    chk("eq_duty", 32'(duty_out), 32'd20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
